// File: rtl/tank_sprite_read_arbiter.sv
// Round-robin arbiter that shares one synchronous-read tank sprite RAM among several
// pixel requesters and returns tagged palette indices three cycles after each grant.
module tank_sprite_read_arbiter #(
    parameter int N_REQ      = 4,
    parameter int ID_W       = 2,
    parameter int SPRITE_W   = 50,
    parameter int SPRITE_H   = 50,
    parameter int ADDR_W     = 19,
    parameter int DATA_W     = 4,
    parameter int TRANSP_IDX = 0
) (
    input  logic                Clk,
    input  logic                Reset,
    input  logic                frame_sync,
    input  logic [N_REQ-1:0]    req,
    input  logic [N_REQ*6-1:0]  req_x,
    input  logic [N_REQ*6-1:0]  req_y,
    input  logic [N_REQ-1:0]    req_flip,
    output logic [N_REQ-1:0]    gnt,
    output logic [ADDR_W-1:0]   ram_read_address,
    input  logic [DATA_W-1:0]   ram_data,
    output logic                rsp_valid,
    output logic [ID_W-1:0]     rsp_id,
    output logic [DATA_W-1:0]   rsp_data,
    output logic                rsp_transparent
);

    logic [ID_W-1:0]   ptr_q, ptr_d;
    logic              gntValid;
    logic [ID_W-1:0]   gntId;

    logic [5:0]        selX, selY;
    logic              selFlip;
    logic              selOor;
    logic [ADDR_W-1:0] selCol;
    logic [ADDR_W-1:0] addr_q, addr_d;

    logic              s1Valid_q, s1Oor_q;
    logic [ID_W-1:0]   s1Id_q;
    logic              s2Valid_q, s2Oor_q;
    logic [ID_W-1:0]   s2Id_q;

    logic              rspValid_q;
    logic [ID_W-1:0]   rspId_q;
    logic [DATA_W-1:0] rspData_q;
    logic              rspTransp_q;

    // Scan from the pointer upward; the first requester found wins the cycle.
    always_comb begin
        gntValid = 1'b0;
        gntId    = '0;
        gnt      = '0;
        for (int off = 0; off < N_REQ; off++) begin
            if (!Reset && !gntValid && req[(int'(ptr_q) + off) % N_REQ]) begin
                gntValid = 1'b1;
                gntId    = ID_W'((int'(ptr_q) + off) % N_REQ);
            end
        end
        if (gntValid) begin
            gnt[gntId] = 1'b1;
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (frame_sync) begin
            ptr_d = '0;
        end else if (gntValid) begin
            ptr_d = (int'(gntId) == N_REQ - 1) ? '0 : gntId + ID_W'(1);
        end
    end

    // Mirrored sprites read the row right-to-left; out-of-range offsets fetch address 0.
    always_comb begin
        selX    = req_x[int'(gntId)*6 +: 6];
        selY    = req_y[int'(gntId)*6 +: 6];
        selFlip = req_flip[gntId];
        selOor  = (int'(selX) >= SPRITE_W) || (int'(selY) >= SPRITE_H);
        selCol  = selFlip ? (ADDR_W'(SPRITE_W - 1) - ADDR_W'(selX)) : ADDR_W'(selX);
        addr_d  = addr_q;
        if (gntValid) begin
            addr_d = selOor ? '0 : (ADDR_W'(selY) * ADDR_W'(SPRITE_W) + selCol);
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            ptr_q       <= '0;
            addr_q      <= '0;
            s1Valid_q   <= 1'b0;
            s1Id_q      <= '0;
            s1Oor_q     <= 1'b0;
            s2Valid_q   <= 1'b0;
            s2Id_q      <= '0;
            s2Oor_q     <= 1'b0;
            rspValid_q  <= 1'b0;
            rspId_q     <= '0;
            rspData_q   <= '0;
            rspTransp_q <= 1'b0;
        end else begin
            ptr_q     <= ptr_d;
            addr_q    <= addr_d;
            s1Valid_q <= gntValid;
            s1Id_q    <= gntId;
            s1Oor_q   <= gntValid && selOor;
            s2Valid_q <= s1Valid_q;
            s2Id_q    <= s1Id_q;
            s2Oor_q   <= s1Oor_q;
            rspValid_q <= s2Valid_q;
            // Bubbles leave the last response fields untouched.
            if (s2Valid_q) begin
                rspId_q     <= s2Id_q;
                rspData_q   <= s2Oor_q ? '0 : ram_data;
                rspTransp_q <= s2Oor_q || (ram_data == DATA_W'(TRANSP_IDX));
            end
        end
    end

    assign ram_read_address = addr_q;
    assign rsp_valid        = rspValid_q;
    assign rsp_id           = rspId_q;
    assign rsp_data         = rspData_q;
    assign rsp_transparent  = rspTransp_q;

endmodule

// File: tb/tb_tank_sprite_read_arbiter.sv
// Directed, table-driven bench for tank_sprite_read_arbiter with a registered sprite RAM model
// and a latency-aligned scoreboard of expected responses.
module tb_tank_sprite_read_arbiter;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        frame_sync = 1'b0;
    logic [3:0]  req = '0;
    logic [23:0] req_x = '0;
    logic [23:0] req_y = '0;
    logic [3:0]  req_flip = '0;
    logic [3:0]  gnt;
    logic [18:0] ram_read_address;
    logic [3:0]  ram_data = '0;
    logic        rsp_valid;
    logic [1:0]  rsp_id;
    logic [3:0]  rsp_data;
    logic        rsp_transparent;

    int checks = 0;
    int errors = 0;

    tank_sprite_read_arbiter dut (
        .Clk(Clk),
        .Reset(Reset),
        .frame_sync(frame_sync),
        .req(req),
        .req_x(req_x),
        .req_y(req_y),
        .req_flip(req_flip),
        .gnt(gnt),
        .ram_read_address(ram_read_address),
        .ram_data(ram_data),
        .rsp_valid(rsp_valid),
        .rsp_id(rsp_id),
        .rsp_data(rsp_data),
        .rsp_transparent(rsp_transparent)
    );

    always #5 Clk = ~Clk;

    // Sprite RAM contents: a few pinned words, the rest derived from the address.
    function automatic logic [3:0] ramWord(input int addr);
        logic [31:0] a;
        a = addr;
        case (addr)
            53:      return 4'hA;
            96:      return 4'h0;
            2499:    return 4'h7;
            default: return a[3:0] ^ 4'h3;
        endcase
    endfunction

    always @(posedge Clk) ram_data <= ramWord(int'(ram_read_address));

    typedef struct {
        logic        rst;
        logic        fs;
        logic [3:0]  req;
        logic [23:0] x;
        logic [23:0] y;
        logic [3:0]  flip;
        logic [3:0]  expGnt;
    } vec_t;

    typedef struct {
        logic       valid;
        logic [1:0] id;
        logic [3:0] data;
        logic       transp;
        int         addr;
    } exp_t;

    vec_t vecs[$];
    exp_t p1, p2, cur, none;
    int   expAddr;
    logic [1:0] lastId;
    logic [3:0] lastData;
    logic       lastTransp;

    function automatic logic [23:0] pk(input int a0, input int a1, input int a2, input int a3);
        logic [5:0] b0, b1, b2, b3;
        b0 = 6'(a0); b1 = 6'(a1); b2 = 6'(a2); b3 = 6'(a3);
        return {b3, b2, b1, b0};
    endfunction

    function automatic vec_t mk(input logic rst, input logic fs, input logic [3:0] r,
                                input logic [23:0] x, input logic [23:0] y,
                                input logic [3:0] flip, input logic [3:0] eg);
        vec_t v;
        v.rst = rst; v.fs = fs; v.req = r; v.x = x; v.y = y; v.flip = flip; v.expGnt = eg;
        return v;
    endfunction

    // Expected response for the requester the table says should win this cycle.
    function automatic exp_t expResp(input vec_t v);
        exp_t e;
        int id, x, y, col;
        e.valid = 1'b0; e.id = '0; e.data = '0; e.transp = 1'b0; e.addr = 0;
        id = -1;
        for (int i = 0; i < 4; i++) if (v.expGnt[i]) id = i;
        if (id < 0) return e;
        x = int'(v.x[id*6 +: 6]);
        y = int'(v.y[id*6 +: 6]);
        e.valid = 1'b1;
        e.id = 2'(id);
        if (x >= 50 || y >= 50) begin
            e.addr = 0; e.data = 4'h0; e.transp = 1'b1;
        end else begin
            col = v.flip[id] ? (49 - x) : x;
            e.addr = y * 50 + col;
            e.data = ramWord(e.addr);
            e.transp = (e.data == 4'h0);
        end
        return e;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic addIdle(input int n);
        for (int i = 0; i < n; i++) vecs.push_back(mk(0, 0, 4'b0000, '0, '0, 4'b0000, 4'b0000));
    endtask

    task automatic applyStimulus(input vec_t v);
        @(negedge Clk);
        Reset = v.rst; frame_sync = v.fs; req = v.req;
        req_x = v.x; req_y = v.y; req_flip = v.flip;
        #1;
        checkOutput("gnt", 32'(gnt), 32'(v.expGnt));
        cur = expResp(v);
        @(posedge Clk);
        #1;
        if (v.rst) begin
            expAddr = 0; p1 = none; p2 = none;
            lastId = '0; lastData = '0; lastTransp = 1'b0;
        end else begin
            if (cur.valid) expAddr = cur.addr;
            if (p2.valid) begin
                lastId = p2.id; lastData = p2.data; lastTransp = p2.transp;
            end
        end
        checkOutput("ram_read_address", 32'(ram_read_address), 32'(expAddr));
        checkOutput("rsp_valid", 32'(rsp_valid), v.rst ? 32'd0 : 32'(p2.valid));
        checkOutput("rsp_id", 32'(rsp_id), 32'(lastId));
        checkOutput("rsp_data", 32'(rsp_data), 32'(lastData));
        checkOutput("rsp_transparent", 32'(rsp_transparent), 32'(lastTransp));
        if (!v.rst) begin
            p2 = p1;
            p1 = cur;
        end
    endtask

    initial begin
        int lat;
        none.valid = 1'b0; none.id = '0; none.data = '0; none.transp = 1'b0; none.addr = 0;
        p1 = none; p2 = none; expAddr = 0;
        lastId = '0; lastData = '0; lastTransp = 1'b0;

        vecs.push_back(mk(1, 0, 4'b1111, pk(1,2,3,4), pk(0,0,0,0), 4'b0000, 4'b0000));
        vecs.push_back(mk(1, 0, 4'b1111, pk(1,2,3,4), pk(0,0,0,0), 4'b0000, 4'b0000));
        addIdle(1);
        vecs.push_back(mk(0, 0, 4'b0100, pk(0,0,3,0), pk(0,0,1,0), 4'b0000, 4'b0100));
        addIdle(3);
        vecs.push_back(mk(0, 0, 4'b0010, pk(0,3,0,0), pk(0,1,0,0), 4'b0010, 4'b0010));
        addIdle(3);
        vecs.push_back(mk(0, 1, 4'b0000, '0, '0, 4'b0000, 4'b0000));
        for (int i = 0; i < 8; i++)
            vecs.push_back(mk(0, 0, 4'b1111, pk(1,2,3,4), pk(0,1,2,3), 4'b0000, 4'(1 << (i % 4))));
        addIdle(3);
        vecs.push_back(mk(0, 0, 4'b0001, pk(50,0,0,0), pk(0,0,0,0), 4'b0000, 4'b0001));
        vecs.push_back(mk(0, 0, 4'b0001, pk(49,0,0,0), pk(49,0,0,0), 4'b0000, 4'b0001));
        addIdle(3);
        vecs.push_back(mk(0, 0, 4'b0010, pk(1,2,3,4), pk(0,1,2,3), 4'b0000, 4'b0010));
        vecs.push_back(mk(0, 1, 4'b1111, pk(1,2,3,4), pk(0,1,2,3), 4'b0000, 4'b0100));
        vecs.push_back(mk(0, 0, 4'b1111, pk(1,2,3,4), pk(0,1,2,3), 4'b0000, 4'b0001));
        addIdle(3);
        vecs.push_back(mk(0, 0, 4'b0010, pk(1,2,3,4), pk(0,1,2,3), 4'b0000, 4'b0010));
        vecs.push_back(mk(1, 0, 4'b1111, pk(1,2,3,4), pk(0,1,2,3), 4'b0000, 4'b0000));
        addIdle(1);
        vecs.push_back(mk(0, 0, 4'b1010, pk(1,2,3,4), pk(0,1,2,3), 4'b0000, 4'b0010));
        addIdle(3);

        foreach (vecs[i]) applyStimulus(vecs[i]);

        // Single fetch from requester 3 (x=0,y=2 -> address 100): measure latency directly.
        @(negedge Clk);
        Reset = 1'b0; frame_sync = 1'b0; req = 4'b1000;
        req_x = pk(0,0,0,0); req_y = pk(0,0,0,2); req_flip = 4'b0000;
        #1;
        checkOutput("single_gnt", 32'(gnt), 32'h8);
        @(posedge Clk);
        #1;
        req = 4'b0000;
        checkOutput("single_addr", 32'(ram_read_address), 32'd100);
        lat = 1;
        while (!rsp_valid && lat < 10) begin
            @(posedge Clk);
            #1;
            lat++;
        end
        checkOutput("single_latency", 32'(lat), 32'd3);
        checkOutput("single_id", 32'(rsp_id), 32'd3);
        checkOutput("single_data", 32'(rsp_data), 32'(ramWord(100)));
        checkOutput("single_transparent", 32'(rsp_transparent), 32'd0);
        @(posedge Clk);
        #1;
        checkOutput("single_pulse_end", 32'(rsp_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
